// File: rtl/fetch_unit.sv
// fetch_unit: IF stage owning the PC, a multi-cycle imem handshake, a stall hold buffer
// and branch redirect that drains an outstanding fetch before reissuing.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  PCWrite_i,
  input  logic        IFIDWrite_i,
  input  logic        Flush_i,
  input  logic [31:0] BranchAddr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] IFID_PC_o,
  output logic [31:0] IFID_inst_o,
  output logic        IFID_valid_o
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, req_addr_q, req_addr_d, ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d, buf_q, buf_d;
  logic ifid_valid_q, ifid_valid_d, adv, ack;
  assign adv = ~(|PCWrite_i) & IFIDWrite_i;
  assign imem_req_o = (state_q == REQ) | (state_q == DROP);
  assign ack = imem_ack_i & imem_req_o;
  assign imem_addr_o = req_addr_q;
  assign pc_o = pc_q;
  assign IFID_PC_o = ifid_pc_q;
  assign IFID_inst_o = ifid_inst_q;
  assign IFID_valid_o = ifid_valid_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    req_addr_d = req_addr_q;
    ifid_pc_d = ifid_pc_q;
    ifid_inst_d = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    buf_d = buf_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = REQ;
        req_addr_d = pc_q;
      end
      REQ: if (ack & adv) begin
        ifid_pc_d = pc_q;
        ifid_inst_d = imem_data_i;
        ifid_valid_d = 1'b1;
        pc_d = pc_q + 32'd4;
        req_addr_d = pc_q + 32'd4;
      end else if (ack) begin
        buf_d = imem_data_i;
        state_d = HOLD;
      end else if (adv) begin
        ifid_inst_d = NOP_INST;
        ifid_valid_d = 1'b0;
      end
      HOLD: if (adv) begin
        ifid_pc_d = pc_q;
        ifid_inst_d = buf_q;
        ifid_valid_d = 1'b1;
        pc_d = pc_q + 32'd4;
        req_addr_d = pc_q + 32'd4;
        state_d = REQ;
      end
      DROP: if (ack) begin
        state_d = REQ;
        req_addr_d = pc_q;
      end
    endcase
    // An unacked request cannot be withdrawn, so it is drained in DROP before redirecting.
    if (Flush_i) begin
      pc_d = BranchAddr_i;
      ifid_inst_d = NOP_INST;
      ifid_valid_d = 1'b0;
      state_d = (state_q == REQ && !ack) ? DROP : (state_d == HOLD) ? REQ : state_d;
      req_addr_d = (state_d == REQ) ? BranchAddr_i : req_addr_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      ifid_pc_q <= 32'd0;
      ifid_inst_q <= NOP_INST;
      ifid_valid_q <= 1'b0;
      buf_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_addr_q <= req_addr_d;
      ifid_pc_q <= ifid_pc_d;
      ifid_inst_q <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
      buf_q <= buf_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run scored against an
// instruction-stream model (expected PC sequence with redirects).
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0, rst = 1, start = 0, ifidw = 1, flush = 0, ack = 0;
  logic [1:0] pcw = 2'b00;
  logic [31:0] ba = 0, mask = 0;
  logic req, valid;
  logic [31:0] addr, data, pc, ifid_pc, inst;
  int checks = 0, passed = 0;

  assign data = addr ^ mask;
  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .PCWrite_i(pcw), .IFIDWrite_i(ifidw),
    .Flush_i(flush), .BranchAddr_i(ba), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_data_i(data), .pc_o(pc), .IFID_PC_o(ifid_pc),
    .IFID_inst_o(inst), .IFID_valid_o(valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; ack = 0; flush = 0; pcw = 2'b00; ifidw = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req !== 1'b0) $display("FAIL reset_req: got %b want 0", req); else passed++;
    checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", pc); else passed++;
    checks++; if (addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", addr); else passed++;
    checks++; if (inst !== NOP) $display("FAIL reset_inst: got %h want %h", inst, NOP); else passed++;
    checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else passed++;
    checks++; if (ifid_pc !== 32'h0) $display("FAIL reset_ifidpc: got %h want 0", ifid_pc); else passed++;
    step();
    checks++; if (req !== 1'b0) $display("FAIL idle_no_start_req: got %b want 0", req); else passed++;
  endtask

  task automatic test_zero_wait();
    start = 1;
    step();
    start = 0;
    checks++; if (req !== 1'b1 || addr !== 32'h0) $display("FAIL zw_first_req: got %b/%h want 1/0", req, addr); else passed++;
    checks++; if (valid !== 1'b0) $display("FAIL zw_valid_c1: got %b want 0", valid); else passed++;
    ack = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (inst !== 32'(4*k) || ifid_pc !== 32'(4*k) || valid !== 1'b1)
        $display("FAIL zw_ifid%0d: got %h/%h/%b want %h/%h/1", k, ifid_pc, inst, valid, 4*k, 4*k); else passed++;
      checks++; if (pc !== 32'(4*k+4) || addr !== 32'(4*k+4))
        $display("FAIL zw_pc%0d: got %h/%h want %h", k, pc, addr, 4*k+4); else passed++;
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] exp_pc = 32'h10;
    for (int i = 0; i < 9; i++) begin
      ack = (i % 3 == 2);
      checks++; if (addr !== exp_pc || req !== 1'b1) $display("FAIL ws_addr%0d: got %h want %h", i, addr, exp_pc); else passed++;
      step();
      checks++; if (valid !== (i % 3 == 2)) $display("FAIL ws_valid%0d: got %b want %b", i, valid, i % 3 == 2); else passed++;
      if (i % 3 == 2) begin
        checks++; if (inst !== exp_pc) $display("FAIL ws_inst%0d: got %h want %h", i, inst, exp_pc); else passed++;
        exp_pc += 4;
      end
    end
  endtask

  task automatic test_hold();
    ack = 1; pcw = 2'b01; ifidw = 0;
    step();
    ack = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (req !== 1'b0) $display("FAIL hold_req%0d: got %b want 0", i, req); else passed++;
      checks++; if (pc !== 32'h1c || inst !== 32'h18 || valid !== 1'b1)
        $display("FAIL hold_frozen%0d: got %h/%h/%b want 1c/18/1", i, pc, inst, valid); else passed++;
      if (i < 2) step();
    end
    pcw = 2'b00; ifidw = 1;
    step();
    checks++; if (inst !== 32'h1c || ifid_pc !== 32'h1c || valid !== 1'b1)
      $display("FAIL hold_release: got %h/%h/%b want 1c/1c/1", ifid_pc, inst, valid); else passed++;
    checks++; if (req !== 1'b1 || addr !== 32'h20 || pc !== 32'h20)
      $display("FAIL hold_resume: got %b/%h/%h want 1/20/20", req, addr, pc); else passed++;
    ack = 1;
    step();
    checks++; if (inst !== 32'h20 || valid !== 1'b1) $display("FAIL hold_next: got %h/%b want 20/1", inst, valid); else passed++;
  endtask

  task automatic test_flush_drop();
    do_reset();
    start = 1;
    step();
    start = 0; ack = 1;
    repeat (4) step();
    ack = 0; flush = 1; ba = 32'h40;
    step();
    flush = 0;
    checks++; if (inst !== NOP || valid !== 1'b0) $display("FAIL fd_nop: got %h/%b want %h/0", inst, valid, NOP); else passed++;
    checks++; if (req !== 1'b1 || addr !== 32'h10 || pc !== 32'h40)
      $display("FAIL fd_drop: got %b/%h/%h want 1/10/40", req, addr, pc); else passed++;
    repeat (2) step();
    checks++; if (addr !== 32'h10 || valid !== 1'b0) $display("FAIL fd_wait: got %h/%b want 10/0", addr, valid); else passed++;
    ack = 1;
    step();
    checks++; if (valid !== 1'b0 || inst !== NOP || addr !== 32'h40)
      $display("FAIL fd_discard: got %h/%b/%h want %h/0/40", inst, valid, addr, NOP); else passed++;
    step();
    checks++; if (inst !== 32'h40 || ifid_pc !== 32'h40 || valid !== 1'b1)
      $display("FAIL fd_target: got %h/%h/%b want 40/40/1", ifid_pc, inst, valid); else passed++;
  endtask

  task automatic test_flush_ack_stall();
    ack = 1; flush = 1; pcw = 2'b01; ba = 32'h80;
    step();
    flush = 0; pcw = 2'b00;
    checks++; if (req !== 1'b1 || addr !== 32'h80 || pc !== 32'h80 || valid !== 1'b0)
      $display("FAIL fas_redirect: got %b/%h/%h/%b want 1/80/80/0", req, addr, pc, valid); else passed++;
    step();
    checks++; if (inst !== 32'h80 || valid !== 1'b1) $display("FAIL fas_target: got %h/%b want 80/1", inst, valid); else passed++;
  endtask

  task automatic test_reset_mid_and_wrap();
    ack = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    checks++; if (req !== 1'b0 || pc !== 32'h0 || valid !== 1'b0)
      $display("FAIL rst_mid: got %b/%h/%b want 0/0/0", req, pc, valid); else passed++;
    start = 1;
    step();
    start = 0; ack = 1; flush = 1; ba = 32'hFFFFFFFC;
    step();
    flush = 0;
    checks++; if (addr !== 32'hFFFFFFFC) $display("FAIL wrap_addr: got %h want fffffffc", addr); else passed++;
    step();
    checks++; if (ifid_pc !== 32'hFFFFFFFC || inst !== 32'hFFFFFFFC || pc !== 32'h0 || addr !== 32'h0)
      $display("FAIL wrap: got %h/%h/%h/%h want fffffffc/fffffffc/0/0", ifid_pc, inst, pc, addr); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] exp_next = 32'h0, p_inst, p_pc, p_addr;
    logic p_valid, p_adv, p_flush, p_req, p_ack;
    int deliveries = 0;
    mask = 32'h5A5A0000;
    do_reset();
    start = 1;
    step();
    start = 0;
    for (int c = 0; c < 3000; c++) begin
      pcw = ($urandom % 4 == 0) ? 2'($urandom) : 2'b00;
      ifidw = ($urandom % 8 != 0);
      flush = ($urandom % 12 == 0);
      ba = {22'd0, 8'($urandom), 2'b00};
      ack = req && ($urandom % 3 != 0);
      p_inst = inst; p_pc = ifid_pc; p_valid = valid; p_addr = addr;
      p_adv = (pcw == 2'b00) && ifidw; p_flush = flush; p_req = req; p_ack = ack;
      step();
      if (p_flush) begin
        checks++; if (valid !== 1'b0 || inst !== NOP) $display("FAIL rnd_flush c%0d: got %h/%b want %h/0", c, inst, valid, NOP); else passed++;
        exp_next = ba;
      end else if (p_adv && valid) begin
        checks++; if (ifid_pc !== exp_next || inst !== (exp_next ^ mask) || pc !== exp_next + 4)
          $display("FAIL rnd_deliver c%0d: got %h/%h/%h want %h/%h/%h", c, ifid_pc, inst, pc, exp_next, exp_next ^ mask, exp_next + 4); else passed++;
        exp_next += 4;
        deliveries++;
      end else if (!p_adv) begin
        checks++; if (inst !== p_inst || ifid_pc !== p_pc || valid !== p_valid)
          $display("FAIL rnd_stall_hold c%0d: got %h/%h/%b want %h/%h/%b", c, ifid_pc, inst, valid, p_pc, p_inst, p_valid); else passed++;
      end
      if (p_req && !p_ack && req) begin
        checks++; if (addr !== p_addr) $display("FAIL rnd_addr_stable c%0d: got %h want %h", c, addr, p_addr); else passed++;
      end
    end
    flush = 0; ack = 0; pcw = 2'b00; ifidw = 1;
    checks++; if (deliveries < 100) $display("FAIL rnd_progress: got %0d want >=100", deliveries); else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_hold();
    test_flush_drop();
    test_flush_ack_stall();
    test_reset_mid_and_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the 5-stage pipeline: owns the PC, issues requests to a multi-cycle instruction memory, and drives the IF/ID pipeline register.
- It is the consumer of the hazard unit's stall outputs (PCWrite, IFIDWrite) and of the ID-stage branch flush.
- It buffers a returned instruction while the pipeline is stalled, inserts bubbles while memory is slow, and discards in-flight fetches on a branch redirect.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INST, 32'h00000013, instruction word placed in IF/ID for bubbles and flushes.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  begins fetching; sampled only in IDLE.
- PCWrite_i  in  2  from hazard unit: 2'b00 advance, 2'b01 hold; 2'b1x is treated as hold.
- IFIDWrite_i  in  1  from hazard unit: 1 = IF/ID may load, 0 = hold.
- Flush_i  in  1  branch taken in ID; redirect to BranchAddr_i.
- BranchAddr_i  in  32  redirect target.
- imem_req_o  out  1  instruction memory request.
- imem_addr_o  out  32  request address; stable while imem_req_o=1.
- imem_ack_i  in  1  memory returns imem_data_i this cycle; valid only while imem_req_o=1.
- imem_data_i  in  32  fetched instruction.
- pc_o  out  32  current PC.
- IFID_PC_o  out  32  PC of the instruction held in IF/ID.
- IFID_inst_o  out  32  instruction held in IF/ID.
- IFID_valid_o  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Definitions:
  - stall = PCWrite_i[0] | PCWrite_i[1] | ~IFIDWrite_i.
  - adv = ~stall.
- Reset (overrides everything, including an outstanding request):
  - pc = RESET_PC; state = IDLE; imem_req_o = 0; imem_addr_o = RESET_PC.
  - IFID_inst_o = NOP_INST; IFID_PC_o = 0; IFID_valid_o = 0; hold buffer cleared.
- States: IDLE, REQ, HOLD, DROP. imem_req_o = 1 in REQ and DROP only.
- imem_addr_o comes from a registered req_addr. req_addr is loaded from the next pc on every entry to REQ and must not change while in REQ or DROP.
- IDLE:
  - start_i=1 -> REQ with req_addr = pc.
  - IF/ID holds NOP, valid=0.
- REQ, ack=0:
  - if adv, IF/ID loads NOP_INST, valid=0 (bubble); otherwise IF/ID holds.
  - pc unchanged.
- REQ, ack=1, adv:
  - IF/ID <= {pc, imem_data_i, valid=1}; pc <= pc+4 (mod 2^32); stay REQ with req_addr = pc+4.
  - Back-to-back acks give 1 instruction/cycle.
- REQ, ack=1, stall:
  - imem_data_i and pc go into the hold buffer; -> HOLD.
  - IF/ID and pc unchanged.
- HOLD:
  - no request; IF/ID holds.
  - On the first cycle with adv: IF/ID <= buffer (valid=1); pc <= pc+4; -> REQ with req_addr = pc+4.
- Flush_i=1 (priority over stall and ack):
  - pc <= BranchAddr_i; IF/ID <= NOP_INST, valid=0; hold buffer discarded.
  - From REQ with ack=1, HOLD, or IDLE-after-start: -> REQ, req_addr = BranchAddr_i.
  - From REQ with ack=0: -> DROP, because the outstanding request cannot be withdrawn.
- DROP:
  - request stays at the old req_addr.
  - On ack: data discarded; -> REQ, req_addr = pc.
  - A further Flush_i in DROP only updates pc.
- Flush_i while stalled still redirects. The hazard unit never asserts stall and flush for the same instruction, so no ordering conflict arises.
- start_i is ignored after leaving IDLE. Only rst_i returns the block to IDLE.

Test Plan:
- Reset, start_i=1, memory with zero-wait ack (always 1), words = address -> IFID_inst_o = 0,4,8,12 on consecutive cycles; IFID_valid_o=1 from cycle 2; pc_o advances by 4 each cycle.
- 2-wait-state memory (ack every 3rd request cycle) -> IFID_valid_o pattern 0,0,1 repeating; imem_addr_o constant during each wait.
- ack=1 with PCWrite_i=2'b01 and IFIDWrite_i=0 held 3 cycles -> state HOLD, imem_req_o=0, IF/ID and pc frozen; on release, the buffered word appears next cycle with valid=1, then fetch resumes at pc+4.
- Flush_i=1, BranchAddr_i=32'h40, while REQ with ack=0 at addr 0x10 -> IF/ID = NOP, valid 0; imem_addr_o stays 0x10 until ack; that data is never loaded; next request is at 0x40.
- Flush_i and ack in the same cycle with stall=1 -> acked data dropped; next imem_addr_o = BranchAddr_i; no HOLD entry.
- rst_i=1 mid-wait with imem_req_o=1 -> next cycle imem_req_o=0, pc_o = RESET_PC, IFID_valid_o=0; pc=32'hFFFFFFFC fetch -> pc wraps to 0.
